// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory requests over a req/addr_ok/data_ok
// SRAM handshake, captures load data, and packs the MEM-to-WB and bypass buses.
module mem_stage #(
    parameter int EX_TO_MEM_BUS_WD = 106,
    parameter int MEM_TO_WB_BUS_WD = 108,
    parameter int MEM_TO_BY_BUS_WD = 39
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic                        EX_to_MEM_valid,
    output logic                        MEM_allow_in,
    input  logic [EX_TO_MEM_BUS_WD-1:0] EX_to_MEM_bus,

    input  logic                        WB_allow_in,
    output logic                        MEM_to_WB_valid,
    output logic [MEM_TO_WB_BUS_WD-1:0] MEM_to_WB_bus,

    output logic [MEM_TO_BY_BUS_WD-1:0] MEM_to_BY_bus,

    output logic                        data_sram_req,
    output logic                        data_sram_wr,
    output logic [3:0]                  data_sram_wstrb,
    output logic [31:0]                 data_sram_addr,
    output logic [31:0]                 data_sram_wdata,
    input  logic                        data_sram_addr_ok,
    input  logic                        data_sram_data_ok,
    input  logic [31:0]                 data_sram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // no memory access outstanding
        S_REQ  = 2'd1,   // request strobe asserted, waiting for addr_ok
        S_WAIT = 2'd2,   // address accepted, waiting for data_ok
        S_DONE = 2'd3    // access complete, waiting for WB to take it
    } state_e;

    state_e                      state_q, state_d;
    logic                        mem_valid_q;
    logic [EX_TO_MEM_BUS_WD-1:0] ex_reg_q;
    logic [31:0]                 rdata_q;

    // Field views of the latched EX bus
    logic        rf_w_en;
    logic        sel_load;
    logic        sel_byte;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [4:0]  rf_w_addr;
    logic [31:0] alu_result;
    logic [31:0] inst_pc;

    assign rf_w_en    = ex_reg_q[105];
    assign sel_load   = ex_reg_q[104];
    assign sel_byte   = ex_reg_q[103];
    assign ram_en     = ex_reg_q[102];
    assign ram_we     = ex_reg_q[101];
    assign ram_wdata  = ex_reg_q[100:69];
    assign rf_w_addr  = ex_reg_q[68:64];
    assign alu_result = ex_reg_q[63:32];
    assign inst_pc    = ex_reg_q[31:0];

    logic       ready_go;
    logic       accept;
    logic       data_taken;
    logic       load_pending;
    logic [3:0] b_en;
    logic [31:0] wb_rdata;

    assign ready_go        = ~ram_en | (state_q == S_DONE);
    assign MEM_to_WB_valid = mem_valid_q & ready_go;
    assign MEM_allow_in    = ~mem_valid_q | (ready_go & WB_allow_in);
    assign accept          = EX_to_MEM_valid & MEM_allow_in;

    // Responses are honoured only while a request is genuinely in flight.
    assign data_taken = ((state_q == S_REQ) & data_sram_addr_ok & data_sram_data_ok)
                      | ((state_q == S_WAIT) & data_sram_data_ok);

    assign b_en = sel_byte ? (4'b0001 << alu_result[1:0]) : 4'b1111;

    assign data_sram_req   = (state_q == S_REQ);
    assign data_sram_wr    = ram_we;
    assign data_sram_wstrb = ram_we ? b_en : 4'b0000;
    assign data_sram_addr  = {alu_result[31:2], 2'b00};
    assign data_sram_wdata = sel_byte ? {4{ram_wdata[7:0]}} : ram_wdata;

    // Only loads carry read data to WB; byte extraction happens there.
    assign wb_rdata = (ram_en & ~ram_we) ? rdata_q : 32'd0;

    assign load_pending = mem_valid_q & sel_load & (state_q != S_DONE);

    // Bus is zeroed when the stage is empty so stale fields never leak out.
    assign MEM_to_WB_bus = mem_valid_q
                         ? {rf_w_en, sel_load, sel_byte, b_en, wb_rdata,
                            rf_w_addr, alu_result, inst_pc}
                         : '0;

    assign MEM_to_BY_bus = {mem_valid_q & rf_w_en, rf_w_addr, alu_result, load_pending};

    // Next-state selection for the memory access sequencer
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = EX_to_MEM_bus[102] ? S_REQ : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_REQ: begin
                    if (data_sram_addr_ok & data_sram_data_ok) state_d = S_DONE;
                    else if (data_sram_addr_ok)               state_d = S_WAIT;
                end
                S_WAIT: if (data_sram_data_ok) state_d = S_DONE;
                S_DONE: if (WB_allow_in)       state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Sequencer state register; reset drops any outstanding request
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Pipeline valid and latched EX payload
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid_q <= 1'b0;
            ex_reg_q    <= '0;
        end else begin
            if (MEM_allow_in) mem_valid_q <= EX_to_MEM_valid;
            if (accept)       ex_reg_q    <= EX_to_MEM_bus;
        end
    end

    // Read data capture on the accepted response
    always_ff @(posedge clk) begin
        if (reset)           rdata_q <= 32'd0;
        else if (data_taken) rdata_q <= data_sram_rdata;
    end

endmodule
